// File: rtl/sifive_scope_hpm_counter.sv
// Hart-0 scope performance counter: holds the event selector, accumulates
// inc pulses into a WIDTH-bit counter and raises a sticky overflow interrupt.
module sifive_scope_hpm_counter #(
  parameter int unsigned WIDTH = 40,  // 33..64
  parameter int unsigned EVT_W = 32   // up to 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reg_wen,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  input  logic             inhibit,
  output logic [EVT_W-1:0] event_sel,
  input  logic             inc,
  output logic             overflow_irq
);

  localparam logic [1:0] ADDR_EVENT    = 2'd0;
  localparam logic [1:0] ADDR_COUNT_LO = 2'd1;
  localparam logic [1:0] ADDR_COUNT_HI = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic [EVT_W-1:0] event_sel_next;
  logic             overflow;
  logic             overflow_next;
  logic             irq_en;
  logic             irq_en_next;
  logic             en;
  logic             wr_event;
  logic             wr_lo;
  logic             wr_hi;
  logic             wr_status;
  logic             wrap;

  always_comb begin
    wr_event  = reg_wen & (reg_addr == ADDR_EVENT);
    wr_lo     = reg_wen & (reg_addr == ADDR_COUNT_LO);
    wr_hi     = reg_wen & (reg_addr == ADDR_COUNT_HI);
    wr_status = reg_wen & (reg_addr == ADDR_STATUS);

    // Enable uses the current selector, so an EVENT write only affects later pulses.
    en   = inc & ~inhibit & (event_sel != '0);
    // A counter write drops the coincident pulse, including its wrap.
    wrap = en & (&count) & ~(wr_lo | wr_hi);

    count_next = count;
    if (wr_lo) begin
      count_next[31:0] = reg_wdata;
    end else if (wr_hi) begin
      count_next[WIDTH-1:32] = reg_wdata[WIDTH-33:0];
    end else if (en) begin
      count_next = count + WIDTH'(1);
    end

    event_sel_next = wr_event ? reg_wdata[EVT_W-1:0] : event_sel;
    irq_en_next    = wr_status ? reg_wdata[1] : irq_en;
    // Set beats the W1C clear when both land on the same edge.
    overflow_next  = wrap | (overflow & ~(wr_status & reg_wdata[0]));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count        <= '0;
      event_sel    <= '0;
      overflow     <= 1'b0;
      irq_en       <= 1'b0;
      overflow_irq <= 1'b0;
    end else begin
      count        <= count_next;
      event_sel    <= event_sel_next;
      overflow     <= overflow_next;
      irq_en       <= irq_en_next;
      overflow_irq <= overflow_next & irq_en_next;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_EVENT:    reg_rdata = 32'(event_sel);
      ADDR_COUNT_LO: reg_rdata = count[31:0];
      ADDR_COUNT_HI: reg_rdata = 32'(count[WIDTH-1:32]);
      ADDR_STATUS:   reg_rdata = {30'b0, irq_en, overflow};
      default:       reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sifive_scope_hpm_counter.sv
// Randomized self-checking bench for sifive_scope_hpm_counter against an
// arithmetic reference model of the counter registers.
module tb_sifive_scope_hpm_counter;

  localparam int WIDTH = 40;
  localparam int EVT_W = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             reg_wen;
  logic [1:0]       reg_addr;
  logic [31:0]      reg_wdata;
  logic [31:0]      reg_rdata;
  logic             inhibit;
  logic [EVT_W-1:0] event_sel;
  logic             inc;
  logic             overflow_irq;

  sifive_scope_hpm_counter #(.WIDTH(WIDTH), .EVT_W(EVT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .reg_wen      (reg_wen),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .inhibit      (inhibit),
    .event_sel    (event_sel),
    .inc          (inc),
    .overflow_irq (overflow_irq)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  longint unsigned m_cnt;
  longint unsigned m_evt;
  bit              m_ovf;
  bit              m_ien;
  bit              m_irq;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_cnt = 0; m_evt = 0; m_ovf = 0; m_ien = 0; m_irq = 0;
  endfunction

  function automatic void model_step(input bit wen, input int addr, input longint unsigned wdata,
                                     input bit inc_i, input bit inh);
    longint unsigned max_cnt = (64'd1 << WIDTH) - 1;
    longint unsigned lo_span = 64'd1 << 32;
    longint unsigned hi_span = 64'd1 << (WIDTH - 32);
    bit counting = inc_i && !inh && (m_evt != 0);
    bit set_ovf = 0;
    if (wen && addr == 1)
      m_cnt = (m_cnt / lo_span) * lo_span + wdata;
    else if (wen && addr == 2)
      m_cnt = (wdata % hi_span) * lo_span + (m_cnt % lo_span);
    else if (counting) begin
      if (m_cnt == max_cnt) begin m_cnt = 0; set_ovf = 1; end
      else m_cnt = m_cnt + 1;
    end
    if (set_ovf) m_ovf = 1;
    else if (wen && addr == 3 && wdata[0]) m_ovf = 0;
    if (wen && addr == 3) m_ien = wdata[1];
    if (wen && addr == 0) m_evt = wdata;
    m_irq = m_ovf && m_ien;
  endfunction

  function automatic longint unsigned model_read(input int addr);
    case (addr)
      0: return m_evt;
      1: return m_cnt % (64'd1 << 32);
      2: return m_cnt / (64'd1 << 32);
      default: return (m_ien ? 2 : 0) + (m_ovf ? 1 : 0);
    endcase
  endfunction

  // Drive one clock's worth of inputs, step the model on the edge, release inputs after it.
  task automatic cycle(input bit wen, input int addr, input logic [31:0] wdata,
                       input bit inc_i, input bit inh);
    reg_wen = wen; reg_addr = 2'(addr); reg_wdata = wdata; inc = inc_i; inhibit = inh;
    @(posedge clock);
    model_step(wen, addr, wdata, inc_i, inh);
    #1;
    reg_wen = 0; inc = 0; inhibit = 0; reg_wdata = '0;
  endtask

  task automatic rd(input string tag, input int addr, input logic [31:0] exp);
    reg_addr = 2'(addr);
    #1;
    check(tag, reg_rdata, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_evt"}, event_sel, m_evt);
    check({tag, "_irq"}, overflow_irq, m_irq);
    for (int a = 0; a < 4; a++) begin
      reg_addr = 2'(a);
      #0.5;
      check($sformatf("%s_rd%0d", tag, a), reg_rdata, model_read(a));
    end
  endtask

  initial begin
    reset = 1; reg_wen = 0; reg_addr = 0; reg_wdata = 0; inhibit = 0; inc = 0;
    model_reset();
    #12 reset = 0;

    // 1: reset values, then three counted pulses
    check("rst_evt", event_sel, 0);
    check("rst_irq", overflow_irq, 0);
    for (int a = 0; a < 4; a++) rd($sformatf("rst_rd%0d", a), a, 0);
    cycle(1, 0, 32'h5, 0, 0);
    repeat (3) cycle(0, 0, 0, 1, 0);
    rd("t1_lo", 1, 3);
    check("t1_evt", event_sel, 5);

    // 2: zero selector or inhibit freezes the count
    cycle(1, 0, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 1, 0);
    rd("t2_sel0", 1, 3);
    cycle(1, 0, 32'h5, 0, 0);
    repeat (10) cycle(0, 0, 0, 1, 1);
    rd("t2_inh", 1, 3);

    // 3: wrap with irq enabled
    cycle(1, 2, 32'hFF, 0, 0);
    cycle(1, 1, 32'hFFFF_FFFE, 0, 0);
    cycle(1, 3, 32'h2, 0, 0);
    cycle(0, 0, 0, 1, 0);
    rd("t3_pre_lo", 1, 32'hFFFF_FFFF);
    rd("t3_pre_hi", 2, 32'hFF);
    check("t3_pre_irq", overflow_irq, 0);
    cycle(0, 0, 0, 1, 0);
    rd("t3_lo", 1, 0);
    rd("t3_hi", 2, 0);
    rd("t3_status", 3, 3);
    check("t3_irq", overflow_irq, 1);

    // 4: counter write drops inc; wrap beats W1C
    cycle(1, 1, 32'h10, 1, 0);
    rd("t4_wr_wins", 1, 32'h10);
    cycle(1, 3, 32'h3, 0, 0);
    rd("t4_clr", 3, 2);
    cycle(1, 2, 32'hFF, 0, 0);
    cycle(1, 1, 32'hFFFF_FFFF, 0, 0);
    cycle(1, 3, 32'h3, 1, 0);
    rd("t4_set_wins", 3, 3);
    rd("t4_wrap_lo", 1, 0);
    check("t4_irq", overflow_irq, 1);

    // 5: W1C without wrap; EVENT write uses the old selector for that pulse
    cycle(1, 3, 32'h3, 0, 0);
    rd("t5_status", 3, 2);
    check("t5_irq", overflow_irq, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 32'h7, 1, 0);
    rd("t5_old_zero", 1, 0);
    check("t5_evt", event_sel, 7);
    cycle(1, 0, 0, 1, 0);
    rd("t5_old_nz", 1, 1);
    check_model("t5");

    // 6: async reset mid-cycle while counting
    cycle(1, 0, 32'h9, 0, 0);
    cycle(1, 3, 32'h2, 0, 0);
    repeat (4) cycle(0, 0, 0, 1, 0);
    reg_addr = 1; inc = 1;
    #2 reset = 1;
    model_reset();
    #1;
    check("t6_evt", event_sel, 0);
    check("t6_irq", overflow_irq, 0);
    rd("t6_lo", 1, 0);
    rd("t6_status", 3, 0);
    reset = 0; inc = 0;
    repeat (3) cycle(0, 0, 0, 1, 0);
    rd("t6_after_lo", 1, 0);

    // random stress
    for (int i = 0; i < 600; i++) begin
      bit          wen = ($urandom_range(0, 3) == 0);
      int          addr = $urandom_range(0, 3);
      logic [31:0] wd;
      case ($urandom_range(0, 3))
        0: wd = $urandom;
        1: wd = 32'hFFFF_FFFF;
        2: wd = 32'hFFFF_FFFF - $urandom_range(0, 6);
        default: wd = $urandom_range(0, 3);
      endcase
      cycle(wen, addr, wd, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
